// File: rtl/shift_reg_univ.sv
// ============================================================================
// Module   : shift_reg_univ
// Purpose  : Parametrised universal shift register with shift/rotate in both
//            directions, parallel load, clear, and a frame counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_reg_univ #(
  parameter int STAGES = 6,
  parameter int DW     = 1,
  parameter int CW     = $clog2(STAGES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [2:0]           mode,
  input  logic [DW-1:0]        x_up,
  input  logic [DW-1:0]        x_dn,
  input  logic [STAGES*DW-1:0] pin,
  output logic [STAGES*DW-1:0] y,
  output logic [DW-1:0]        sout_up,
  output logic [DW-1:0]        sout_dn,
  output logic [CW-1:0]        count,
  output logic                 frame_done
);

  localparam logic [2:0] c_hold     = 3'b000;
  localparam logic [2:0] c_shift_up = 3'b001;
  localparam logic [2:0] c_shift_dn = 3'b010;
  localparam logic [2:0] c_rot_up   = 3'b011;
  localparam logic [2:0] c_rot_dn   = 3'b100;
  localparam logic [2:0] c_load     = 3'b101;
  localparam logic [2:0] c_clear    = 3'b110;

  localparam logic [CW-1:0] c_last = CW'(STAGES - 1);
  localparam int            c_top  = STAGES * DW;

  logic [c_top-1:0] r_y;
  logic [CW-1:0]    r_count;
  logic             r_frame_done;
  logic [c_top-1:0] w_next;
  logic             w_is_shift;
  logic             w_is_reload;

  // Stage 0 sits in the least-significant lane, so "up" is a left shift.
  always_comb begin
    w_next = r_y;
    case (mode)
      c_shift_up: w_next = {r_y[c_top-DW-1:0], x_up};
      c_shift_dn: w_next = {x_dn, r_y[c_top-1:DW]};
      c_rot_up:   w_next = {r_y[c_top-DW-1:0], r_y[c_top-1 -: DW]};
      c_rot_dn:   w_next = {r_y[DW-1:0], r_y[c_top-1:DW]};
      c_load:     w_next = pin;
      c_clear:    w_next = '0;
      default:    w_next = r_y;
    endcase
  end

  assign w_is_shift  = (mode == c_shift_up) || (mode == c_shift_dn) ||
                       (mode == c_rot_up)   || (mode == c_rot_dn);
  assign w_is_reload = (mode == c_load) || (mode == c_clear);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y          <= '0;
      r_count      <= '0;
      r_frame_done <= 1'b0;
    end else if (!en) begin
      r_frame_done <= 1'b0;
    end else begin
      r_y          <= w_next;
      r_frame_done <= 1'b0;
      if (w_is_shift) begin
        // Explicit wrap compare so non-power-of-two STAGES wrap correctly.
        if (r_count == c_last) begin
          r_count      <= '0;
          r_frame_done <= 1'b1;
        end else begin
          r_count <= r_count + 1'b1;
        end
      end else if (w_is_reload) begin
        r_count <= '0;
      end
    end
  end

  assign y          = r_y;
  assign sout_up    = r_y[c_top-1 -: DW];
  assign sout_dn    = r_y[DW-1:0];
  assign count      = r_count;
  assign frame_done = r_frame_done;

  // Mode value kept for readability of the encoding table above.
  logic w_unused_hold;
  assign w_unused_hold = (c_hold == 3'b000);

endmodule

`default_nettype wire

// File: tb/tb_shift_reg_univ.sv
// Bench for shift_reg_univ: three instances (6x1, 4x4, 2x2) driven in lockstep,
// checked every cycle against a queue-based model plus directed literals.
`default_nettype none

module tb_shift_reg_univ;

  localparam logic [2:0] M_HOLD = 3'd0, M_SU = 3'd1, M_SD = 3'd2, M_RU = 3'd3,
                         M_RD = 3'd4, M_LOAD = 3'd5, M_CLR = 3'd6, M_RSV = 3'd7;

  typedef int iq_t[$];

  logic clk, rst, en;
  logic [2:0] mode;
  logic [0:0] xu_a, xd_a, so_up_a, so_dn_a, fd_a_v;
  logic [3:0] xu_b, xd_b, so_up_b, so_dn_b;
  logic [1:0] xu_c, xd_c, so_up_c, so_dn_c;
  logic [5:0]  pin_a, y_a;
  logic [15:0] pin_b, y_b;
  logic [3:0]  pin_c, y_c;
  logic [2:0] cnt_a;
  logic [1:0] cnt_b;
  logic [0:0] cnt_c;
  logic fd_a, fd_b, fd_c;

  shift_reg_univ #(.STAGES(6), .DW(1)) u_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .x_up(xu_a), .x_dn(xd_a),
    .pin(pin_a), .y(y_a), .sout_up(so_up_a), .sout_dn(so_dn_a),
    .count(cnt_a), .frame_done(fd_a));
  shift_reg_univ #(.STAGES(4), .DW(4)) u_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .x_up(xu_b), .x_dn(xd_b),
    .pin(pin_b), .y(y_b), .sout_up(so_up_b), .sout_dn(so_dn_b),
    .count(cnt_b), .frame_done(fd_b));
  shift_reg_univ #(.STAGES(2), .DW(2)) u_c (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .x_up(xu_c), .x_dn(xd_c),
    .pin(pin_c), .y(y_c), .sout_up(so_up_c), .sout_dn(so_dn_c),
    .count(cnt_c), .frame_done(fd_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  n_vec = 0;
  int  n_bad = 0;
  bit  chk_on = 0;
  iq_t qa, qb, qc;
  int  ca = 0, cb = 0, cc = 0;
  bit  fa = 0, fb = 0, fc = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic iq_t unpack(input logic [31:0] v, input int n, input int dw);
    iq_t q;
    for (int i = 0; i < n; i++) q.push_back(int'((v >> (i * dw)) & ((32'd1 << dw) - 1)));
    return q;
  endfunction

  function automatic logic [31:0] pack(input iq_t q, input int dw);
    logic [31:0] r = '0;
    for (int i = 0; i < q.size(); i++) r = r | (32'(q[i]) << (i * dw));
    return r;
  endfunction

  // Reference: stages as a queue (index 0 = stage 0), counter modulo n.
  task automatic mstep(input iq_t qi, input int ci, input int n, input int dw,
                       input bit r, input bit e, input logic [2:0] m,
                       input int xu, input int xd, input logic [31:0] p,
                       output iq_t qo, output int co, output bit fo);
    int mask = (1 << dw) - 1;
    int t;
    qo = qi; co = ci; fo = 0;
    if (r) begin
      qo = unpack(32'd0, n, dw);
      co = 0;
    end else if (e) begin
      case (m)
        M_SU: begin t = qo.pop_back();  qo.push_front(xu & mask); end
        M_SD: begin t = qo.pop_front(); qo.push_back(xd & mask); end
        M_RU: begin t = qo.pop_back();  qo.push_front(t); end
        M_RD: begin t = qo.pop_front(); qo.push_back(t); end
        M_LOAD: qo = unpack(p, n, dw);
        M_CLR:  qo = unpack(32'd0, n, dw);
        default: ;
      endcase
      if (m >= M_SU && m <= M_RD) begin
        co = ci + 1;
        if (co == n) begin co = 0; fo = 1; end
      end else if (m == M_LOAD || m == M_CLR) begin
        co = 0;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit e, input logic [2:0] m, input int xu, input int xd,
                     input logic [5:0] pa, input logic [15:0] pb, input logic [3:0] pc);
    iq_t t;
    rst = r; en = e; mode = m;
    xu_a = 1'(xu); xu_b = 4'(xu); xu_c = 2'(xu);
    xd_a = 1'(xd); xd_b = 4'(xd); xd_c = 2'(xd);
    pin_a = pa; pin_b = pb; pin_c = pc;
    @(posedge clk);
    mstep(qa, ca, 6, 1, r, e, m, xu, xd, 32'(pa), t, ca, fa); qa = t;
    mstep(qb, cb, 4, 4, r, e, m, xu, xd, 32'(pb), t, cb, fb); qb = t;
    mstep(qc, cc, 2, 2, r, e, m, xu, xd, 32'(pc), t, cc, fc); qc = t;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("a.y", 32'(y_a), pack(qa, 1));
      cmp("a.sout_up", 32'(so_up_a), 32'(qa[5]));
      cmp("a.sout_dn", 32'(so_dn_a), 32'(qa[0]));
      cmp("a.count", 32'(cnt_a), 32'(ca));
      cmp("a.frame_done", 32'(fd_a), 32'(fa));
      cmp("b.y", 32'(y_b), pack(qb, 4));
      cmp("b.sout_up", 32'(so_up_b), 32'(qb[3]));
      cmp("b.sout_dn", 32'(so_dn_b), 32'(qb[0]));
      cmp("b.count", 32'(cnt_b), 32'(cb));
      cmp("b.frame_done", 32'(fd_b), 32'(fb));
      cmp("c.y", 32'(y_c), pack(qc, 2));
      cmp("c.sout_up", 32'(so_up_c), 32'(qc[1]));
      cmp("c.sout_dn", 32'(so_dn_c), 32'(qc[0]));
      cmp("c.count", 32'(cnt_c), 32'(cc));
      cmp("c.frame_done", 32'(fd_c), 32'(fc));
    end
  end

  initial begin
    logic [5:0] pat;
    logic [5:0] exp_up [4];
    int n_fd;
    exp_up = '{6'b000001, 6'b000011, 6'b000111, 6'b001110};
    pat = 6'b101101;
    fd_a_v = '0;
    rst = 1'b1; en = 1'b0; mode = M_HOLD;
    xu_a = '0; xu_b = '0; xu_c = '0; xd_a = '0; xd_b = '0; xd_c = '0;
    pin_a = '0; pin_b = '0; pin_c = '0;
    @(negedge clk);
    cyc(1, 0, M_HOLD, 0, 0, 6'h0, 16'h0, 4'h0);
    chk_on = 1;
    cmp("lit.reset_y", 32'(y_a), 32'h0);

    // Reset clears a fully-loaded register, beating LOAD.
    cyc(0, 1, M_LOAD, 0, 0, 6'h3f, 16'hffff, 4'hf);
    cmp("lit.load_ones", 32'(y_a), 32'h3f);
    cyc(1, 1, M_LOAD, 0, 0, 6'h3f, 16'hffff, 4'hf);
    cmp("lit.rst_y", 32'(y_b), 32'h0);
    cmp("lit.rst_cnt", 32'(cnt_a), 32'h0);
    cmp("lit.rst_fd", 32'(fd_a), 32'h0);

    // Shift up
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, M_SU, (i < 3) ? 1 : 0, 0, 6'h0, 16'h0, 4'h0);
      cmp("lit.shift_up_y", 32'(y_a), 32'(exp_up[i]));
    end
    cmp("lit.shift_up_cnt", 32'(cnt_a), 32'd4);
    cmp("lit.shift_up_fd", 32'(fd_a), 32'd0);

    // Parallel to serial
    cyc(0, 1, M_LOAD, 0, 0, 6'b101101, 16'h4321, 4'b1001);
    for (int i = 0; i < 6; i++) begin
      cmp("lit.p2s_sout_dn", 32'(so_dn_a), 32'(pat[i]));
      cyc(0, 1, M_SD, 0, 0, 6'h0, 16'h0, 4'h0);
      if (i < 5) cmp("lit.p2s_fd_early", 32'(fd_a), 32'd0);
    end
    cmp("lit.p2s_fd", 32'(fd_a), 32'd1);
    cmp("lit.p2s_cnt", 32'(cnt_a), 32'd0);

    // Rotate, including the two-stage swap
    cyc(0, 1, M_LOAD, 0, 0, 6'b101101, 16'h4321, 4'b1001);
    cyc(0, 1, M_RU, 0, 0, 6'h0, 16'h0, 4'h0);
    cmp("lit.rot_up_b", 32'(y_b), 32'h3214);
    cmp("lit.rot_swap_c", 32'(y_c), 32'h6);
    cyc(0, 1, M_RD, 0, 0, 6'h0, 16'h0, 4'h0);
    cyc(0, 1, M_RD, 0, 0, 6'h0, 16'h0, 4'h0);
    cmp("lit.rot_dn_b", 32'(y_b), 32'h1432);
    cmp("lit.rot_cnt_b", 32'(cnt_b), 32'd3);

    // Enable drop and reserved mode hold mid-frame
    cyc(0, 1, M_LOAD, 0, 0, 6'b110010, 16'hbeef, 4'b0110);
    cyc(0, 1, M_SU, 1, 2, 6'h0, 16'h0, 4'h0);
    cyc(0, 1, M_SD, 0, 5, 6'h0, 16'h0, 4'h0);
    for (int i = 0; i < 3; i++) cyc(0, 0, M_SU, 1, 1, 6'h3f, 16'hffff, 4'hf);
    for (int i = 0; i < 2; i++) cyc(0, 1, M_RSV, 1, 1, 6'h3f, 16'hffff, 4'hf);
    cmp("lit.hold_cnt", 32'(cnt_a), 32'd2);
    cmp("lit.hold_fd", 32'(fd_a), 32'd0);
    for (int i = 0; i < 4; i++) cyc(0, 1, M_RU, 0, 0, 6'h0, 16'h0, 4'h0);
    cmp("lit.resume_fd", 32'(fd_a), 32'd1);
    cyc(0, 1, M_HOLD, 0, 0, 6'h0, 16'h0, 4'h0);
    cmp("lit.hold_fd_clear", 32'(fd_a), 32'd0);

    // Reset mid-frame, then exactly one frame_done per frame
    cyc(0, 1, M_LOAD, 0, 0, 6'b011011, 16'h1234, 4'b1100);
    for (int i = 0; i < 3; i++) cyc(0, 1, M_SU, 1, 0, 6'h0, 16'h0, 4'h0);
    cyc(1, 1, M_LOAD, 0, 0, 6'h3f, 16'hffff, 4'hf);
    cmp("lit.midrst_y", 32'(y_a), 32'h0);
    cmp("lit.midrst_cnt", 32'(cnt_a), 32'd0);
    cyc(0, 1, M_LOAD, 0, 0, 6'b100111, 16'hcafe, 4'b0011);
    n_fd = 0;
    for (int i = 0; i < 7; i++) begin
      cyc(0, 1, (i < 6) ? M_SD : M_HOLD, 0, 1, 6'h0, 16'h0, 4'h0);
      if (fd_a) n_fd++;
    end
    cmp("lit.one_frame_done", 32'(n_fd), 32'd1);
    cyc(0, 1, M_CLR, 0, 0, 6'h0, 16'h0, 4'h0);
    cmp("lit.clear_y", 32'(y_b), 32'h0);

    chk_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
